// File: rtl/psum_accumulator.sv
// Four-lane partial-sum accumulator.
// Sums a configured number of signed column partial sums per lane into
// saturating ACC_W-bit totals and offers them downstream on a valid/ready
// handshake. Totals stay stable in HOLD until the downstream consumes them.
module psum_accumulator #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 18,
  parameter int MAX_TILES = 16,
  parameter int CNT_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        cfg_tiles,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  psi1,
  input  logic signed [IN_W-1:0]  psi2,
  input  logic signed [IN_W-1:0]  psi3,
  input  logic signed [IN_W-1:0]  psi4,
  output logic signed [ACC_W-1:0] pso1,
  output logic signed [ACC_W-1:0] pso2,
  output logic signed [ACC_W-1:0] pso3,
  output logic signed [ACC_W-1:0] pso4,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              sat,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Clamp bounds expressed one bit wider than the accumulator so the
  // unclamped sum can be compared directly.
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic [CNT_W-1:0]        tiles;
  logic [CNT_W-1:0]        count;
  logic signed [ACC_W-1:0] acc   [4];
  logic signed [IN_W-1:0]  psi   [4];
  logic signed [ACC_W:0]   wide  [4];
  logic signed [ACC_W-1:0] nxt   [4];
  logic [3:0]              clamp;
  logic [CNT_W-1:0]        tiles_eff;
  logic                    last_beat;

  assign psi[0] = psi1;
  assign psi[1] = psi2;
  assign psi[2] = psi3;
  assign psi[3] = psi4;

  assign pso1 = acc[0];
  assign pso2 = acc[1];
  assign pso3 = acc[2];
  assign pso4 = acc[3];

  // Handshake pulse; out_valid is registered and only high in HOLD.
  assign done = out_valid & out_ready;

  // Zero tiles means one; anything above MAX_TILES is capped.
  always_comb begin
    tiles_eff = cfg_tiles;
    if (cfg_tiles == '0)
      tiles_eff = CNT_W'(1);
    else if (cfg_tiles > CNT_W'(MAX_TILES))
      tiles_eff = CNT_W'(MAX_TILES);
  end

  assign last_beat = (count == tiles - CNT_W'(1));

  // Per-lane widened sum with clamping to the accumulator range.
  always_comb begin
    clamp = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wide[i] = {acc[i][ACC_W-1], acc[i]}
              + {{(ACC_W+1-IN_W){psi[i][IN_W-1]}}, psi[i]};
      nxt[i]  = wide[i][ACC_W-1:0];
      if (wide[i] > ACC_MAX) begin
        nxt[i]   = ACC_MAX[ACC_W-1:0];
        clamp[i] = 1'b1;
      end else if (wide[i] < ACC_MIN) begin
        nxt[i]   = ACC_MIN[ACC_W-1:0];
        clamp[i] = 1'b1;
      end
    end
  end

  // Control FSM with registered handshake/status outputs and lane accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tiles     <= '0;
      count     <= '0;
      sat       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++)
        acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tiles    <= tiles_eff;
            count    <= '0;
            sat      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
            for (int unsigned i = 0; i < 4; i++)
              acc[i] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < 4; i++)
              acc[i] <= nxt[i];
            sat   <= sat | clamp;
            count <= count + CNT_W'(1);
            if (last_beat) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator.
module tb_psum_accumulator;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        cfg_tiles;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] psi1, psi2, psi3, psi4;
  logic signed [17:0] pso1, pso2, pso3, pso4;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        sat;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  psum_accumulator #(
    .IN_W(16), .ACC_W(18), .MAX_TILES(16), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_tiles(cfg_tiles),
    .in_valid(in_valid), .in_ready(in_ready),
    .psi1(psi1), .psi2(psi2), .psi3(psi3), .psi4(psi4),
    .pso1(pso1), .pso2(pso2), .pso3(pso3), .pso4(pso4),
    .out_valid(out_valid), .out_ready(out_ready),
    .sat(sat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pso(input string tag, input int e1, input int e2,
                         input int e3, input int e4);
    chk({tag, ".pso1"}, pso1, e1);
    chk({tag, ".pso2"}, pso2, e2);
    chk({tag, ".pso3"}, pso3, e3);
    chk({tag, ".pso4"}, pso4, e4);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_set(input int t);
    start     = 1'b1;
    cfg_tiles = t[4:0];
    tick();
    start     = 1'b0;
  endtask

  task automatic beat(input int a, input int b, input int c, input int d);
    in_valid = 1'b1;
    psi1 = a[15:0];
    psi2 = b[15:0];
    psi3 = c[15:0];
    psi4 = d[15:0];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    #1;
    chk({tag, ".done_hs"}, done, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".ov_after"}, out_valid, 0);
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".done_after"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_tiles = '0; in_valid = 1'b0;
    out_ready = 1'b0; psi1 = '0; psi2 = '0; psi3 = '0; psi4 = '0;
    tick();
    tick();
    // Reset state
    chk_pso("rst", 0, 0, 0, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.sat", sat, 0);
    chk("rst.done", done, 0);
    rst = 1'b0;
    tick();

    // T1: three beats
    start_set(3);
    chk("t1.busy", busy, 1);
    chk("t1.in_ready", in_ready, 1);
    beat(10, -5, 0, 40);
    chk("t1.ov_b1", out_valid, 0);
    beat(20, -5, 0, 40);
    chk("t1.ov_b2", out_valid, 0);
    beat(30, -40, 0, 47);
    chk("t1.ov_b3", out_valid, 1);
    chk("t1.in_ready_hold", in_ready, 0);
    chk_pso("t1", 60, -50, 0, 127);
    chk("t1.sat", sat, 0);
    chk("t1.done", done, 0);

    // T2: back-pressure for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2.ov", out_valid, 1);
      chk("t2.in_ready", in_ready, 0);
      chk("t2.done", done, 0);
      chk_pso("t2", 60, -50, 0, 127);
    end
    handshake("t2");

    // T3: sixteen extreme beats; lanes 1 and 2 saturate
    start_set(16);
    for (int i = 0; i < 4; i++) beat(32767, -32768, 0, 0);
    chk("t3.pso1_b4", pso1, 131068);
    chk("t3.pso2_b4", pso2, -131072);
    chk("t3.sat_b4", sat, 0);
    beat(32767, -32768, 0, 0);
    chk("t3.sat_b5", sat, 3);
    for (int i = 0; i < 10; i++) beat(32767, -32768, 0, 0);
    chk("t3.ov_b15", out_valid, 0);
    beat(32767, -32768, 0, 0);
    chk("t3.ov_b16", out_valid, 1);
    chk_pso("t3", 131071, -131072, 0, 0);
    chk("t3.sat", sat, 3);
    handshake("t3");

    // T3b: clamped lane recovers when a beat pulls it back in range
    start_set(6);
    chk("t3b.sat_cleared", sat, 0);
    for (int i = 0; i < 5; i++) beat(32767, 0, 0, 0);
    chk("t3b.pso1_clamped", pso1, 131071);
    beat(-100, 0, 0, 0);
    chk("t3b.ov", out_valid, 1);
    chk("t3b.pso1", pso1, 130971);
    chk("t3b.sat", sat, 1);
    handshake("t3b");

    // T4: cfg_tiles=0 treated as one
    start_set(0);
    beat(7, -7, 1, -1);
    chk("t4.ov", out_valid, 1);
    chk_pso("t4", 7, -7, 1, -1);
    handshake("t4");

    // T5: reset mid-accumulation discards partial sums
    start_set(4);
    beat(1, 2, 3, 4);
    beat(1, 2, 3, 4);
    chk("t5.pso4_partial", pso4, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_pso("t5.rst", 0, 0, 0, 0);
    chk("t5.busy", busy, 0);
    chk("t5.in_ready", in_ready, 0);
    chk("t5.out_valid", out_valid, 0);
    chk("t5.done", done, 0);
    start_set(1);
    beat(5, 5, 5, 5);
    chk("t5.ov", out_valid, 1);
    chk_pso("t5", 5, 5, 5, 5);
    handshake("t5");

    // T6: gaps and ignored starts
    start_set(3);
    beat(1, 1, 1, 1);
    psi1 = 16'sd100; psi2 = 16'sd100; psi3 = 16'sd100; psi4 = 16'sd100;
    tick();
    chk_pso("t6.gap", 1, 1, 1, 1);
    start = 1'b1; cfg_tiles = 5'd1;
    tick();
    start = 1'b0;
    chk("t6.ov_start_accum", out_valid, 0);
    chk("t6.in_ready_start_accum", in_ready, 1);
    chk("t6.pso1_start_accum", pso1, 1);
    beat(2, 2, 2, 2);
    chk("t6.ov_b2", out_valid, 0);
    beat(3, 3, 3, 3);
    chk("t6.ov_b3", out_valid, 1);
    chk_pso("t6", 6, 6, 6, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.ov_start_hold", out_valid, 1);
    chk("t6.pso1_start_hold", pso1, 6);
    handshake("t6");
    tick();
    chk("t6.idle_busy", busy, 0);
    chk("t6.idle_in_ready", in_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
